// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module  : cdb_arbiter
// Brief   : Round-robin arbiter placing up to N_PORTS FU writebacks per cycle
//           onto registered common-data-bus slots; flush kills new grants.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter #(
  parameter int N_REQ     = 4,
  parameter int N_PORTS   = 2,
  parameter int ROB_DEPTH = 8,
  parameter int PREG_W    = 6,
  parameter int DATA_W    = 32,
  localparam int RID_W    = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ-1:0][RID_W-1:0]     req_rob_id,
  input  logic [N_REQ-1:0][PREG_W-1:0]    req_pd,
  input  logic [N_REQ-1:0][DATA_W-1:0]    req_data,
  output logic [N_REQ-1:0]                req_ready,
  output logic [N_PORTS-1:0]              cdb_valid,
  output logic [N_PORTS-1:0][RID_W-1:0]   cdb_rob_id,
  output logic [N_PORTS-1:0][PREG_W-1:0]  cdb_pd,
  output logic [N_PORTS-1:0][DATA_W-1:0]  cdb_data
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(N_PORTS + 1);
  localparam logic [PTR_W:0]   c_nreq   = (PTR_W+1)'(N_REQ);
  localparam logic [CNT_W-1:0] c_nports = CNT_W'(N_PORTS);

  logic [PTR_W-1:0]              r_rr_ptr;
  logic [N_PORTS-1:0]            r_cdb_valid;
  logic [N_PORTS-1:0][RID_W-1:0] r_cdb_rob_id;
  logic [N_PORTS-1:0][PREG_W-1:0] r_cdb_pd;
  logic [N_PORTS-1:0][DATA_W-1:0] r_cdb_data;

  logic [N_REQ-1:0]              w_grant;
  logic [N_PORTS-1:0]            w_slot_vld;
  logic [N_PORTS-1:0][PTR_W-1:0] w_slot_src;
  logic [PTR_W-1:0]              w_last;
  logic [PTR_W-1:0]              w_idx;
  logic [PTR_W:0]                w_sum;
  logic [PTR_W:0]                w_nsum;
  logic [PTR_W-1:0]              w_next_ptr;
  logic [CNT_W-1:0]              w_cnt;
  logic                          w_any;

  // Scan from r_rr_ptr with wraparound; the k-th winner lands on slot k.
  always_comb begin
    w_grant    = '0;
    w_slot_vld = '0;
    w_slot_src = '0;
    w_last     = r_rr_ptr;
    w_idx      = '0;
    w_sum      = '0;
    w_cnt      = '0;
    w_any      = 1'b0;
    if (!rst && !flush) begin
      for (int k = 0; k < N_REQ; k++) begin
        w_sum = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
        if (w_sum >= c_nreq) w_sum = w_sum - c_nreq;
        w_idx = w_sum[PTR_W-1:0];
        if (req_valid[w_idx] && (w_cnt < c_nports)) begin
          w_grant[w_idx] = 1'b1;
          for (int p = 0; p < N_PORTS; p++) begin
            if (w_cnt == CNT_W'(p)) begin
              w_slot_vld[p] = 1'b1;
              w_slot_src[p] = w_idx;
            end
          end
          w_last = w_idx;
          w_any  = 1'b1;
          w_cnt  = w_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_nsum     = {1'b0, w_last} + (PTR_W+1)'(1);
    w_next_ptr = (w_nsum >= c_nreq) ? '0 : w_nsum[PTR_W-1:0];
  end

  // Payload registers hold their last value on idle slots; only valid is cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr     <= '0;
      r_cdb_valid  <= '0;
      r_cdb_rob_id <= '0;
      r_cdb_pd     <= '0;
      r_cdb_data   <= '0;
    end else begin
      r_cdb_valid <= w_slot_vld;
      for (int p = 0; p < N_PORTS; p++) begin
        if (w_slot_vld[p]) begin
          r_cdb_rob_id[p] <= req_rob_id[w_slot_src[p]];
          r_cdb_pd[p]     <= req_pd[w_slot_src[p]];
          r_cdb_data[p]   <= req_data[w_slot_src[p]];
        end
      end
      if (w_any) r_rr_ptr <= w_next_ptr;
    end
  end

  assign req_ready  = w_grant;
  assign cdb_valid  = r_cdb_valid;
  assign cdb_rob_id = r_cdb_rob_id;
  assign cdb_pd     = r_cdb_pd;
  assign cdb_data   = r_cdb_data;

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module  : tb_cdb_arbiter
// Brief   : Directed, table-driven self-checking bench for cdb_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cdb_arbiter;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   flush;
  logic [3:0]             req_valid;
  logic [3:0][2:0]        req_rob_id;
  logic [3:0][5:0]        req_pd;
  logic [3:0][31:0]       req_data;
  logic [3:0]             req_ready;
  logic [1:0]             cdb_valid;
  logic [1:0][2:0]        cdb_rob_id;
  logic [1:0][5:0]        cdb_pd;
  logic [1:0][31:0]       cdb_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(
    .N_REQ(4), .N_PORTS(2), .ROB_DEPTH(8), .PREG_W(6), .DATA_W(32)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_rob_id(req_rob_id), .req_pd(req_pd), .req_data(req_data),
    .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_pd(cdb_pd), .cdb_data(cdb_data)
  );

  typedef struct {
    logic            flush;
    logic [3:0]      valid;
    logic [3:0][2:0] rob;
    logic [3:0]      exp_ready;
    logic [1:0]      exp_cv;
    int              src0;
    int              src1;
  } vec_t;

  function automatic logic [5:0] pd_of(input int i, input logic [2:0] rob);
    return 6'(i * 8) + 6'(rob);
  endfunction

  function automatic logic [31:0] data_of(input int i, input logic [2:0] rob);
    return 32'hC0DE_0000 + 32'(i * 256) + 32'(rob);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    flush      = 1'b0;
    req_valid  = '0;
    req_rob_id = '0;
    req_pd     = '0;
    req_data   = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t vecs [14];

  initial begin
    rst = 1'b1;
    idle_inputs();

    // Reset held two cycles with every FU requesting.
    req_valid = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1 check($sformatf("reset_ready_c%0d", c), 32'(req_ready), 32'h0);
      @(posedge clk);
      #1 check($sformatf("reset_cdbv_c%0d", c), 32'(cdb_valid), 32'h0);
      check($sformatf("reset_rob_c%0d", c), 32'(cdb_rob_id), 32'h0);
      check($sformatf("reset_data_c%0d", c), 32'(cdb_data[0]), 32'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1 check("post_reset_ptr0_ready", 32'(req_ready), 32'h3);
    req_valid = '0;

    // Single request from FU2.
    @(negedge clk);
    req_valid     = 4'b0100;
    req_rob_id[2] = 3'd5;
    req_pd[2]     = 6'd17;
    req_data[2]   = 32'hDEADBEEF;
    #1 check("single_ready", 32'(req_ready), 32'h4);
    @(posedge clk);
    #1 check("single_cdbv", 32'(cdb_valid), 32'h1);
    check("single_rob", 32'(cdb_rob_id[0]), 32'd5);
    check("single_pd", 32'(cdb_pd[0]), 32'd17);
    check("single_data", cdb_data[0], 32'hDEADBEEF);
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
    #1 check("single_after_cdbv", 32'(cdb_valid), 32'h0);

    // Mid-operation reset: requests held valid are blocked while rst is high.
    @(negedge clk);
    rst = 1'b1;
    req_valid = 4'b1010;
    #1 check("midreset_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1 check("midreset_cdbv", 32'(cdb_valid), 32'h0);
    do_reset();

    // Sequential script; rr pointer starts at 0 and carries across rows.
    vecs[0]  = '{1'b0, 4'b1111, {3'd4,3'd3,3'd2,3'd1}, 4'b0011, 2'b11, 0, 1};
    vecs[1]  = '{1'b0, 4'b1111, {3'd4,3'd3,3'd2,3'd1}, 4'b1100, 2'b11, 2, 3};
    vecs[2]  = '{1'b0, 4'b1111, {3'd6,3'd5,3'd7,3'd0}, 4'b0011, 2'b11, 0, 1};
    vecs[3]  = '{1'b0, 4'b0100, {3'd0,3'd2,3'd0,3'd0}, 4'b0100, 2'b01, 2, 0};
    vecs[4]  = '{1'b0, 4'b1001, {3'd3,3'd0,3'd0,3'd6}, 4'b1001, 2'b11, 3, 0};
    vecs[5]  = '{1'b0, 4'b1111, {3'd1,3'd2,3'd3,3'd4}, 4'b0110, 2'b11, 1, 2};
    vecs[6]  = '{1'b0, 4'b0000, {3'd0,3'd0,3'd0,3'd0}, 4'b0000, 2'b00, 0, 0};
    vecs[7]  = '{1'b0, 4'b1111, {3'd7,3'd6,3'd5,3'd4}, 4'b1001, 2'b11, 3, 0};
    vecs[8]  = '{1'b1, 4'b0010, {3'd0,3'd0,3'd3,3'd0}, 4'b0000, 2'b00, 0, 0};
    vecs[9]  = '{1'b0, 4'b0010, {3'd0,3'd0,3'd3,3'd0}, 4'b0010, 2'b01, 1, 0};
    vecs[10] = '{1'b0, 4'b0001, {3'd0,3'd0,3'd0,3'd1}, 4'b0001, 2'b01, 0, 0};
    vecs[11] = '{1'b0, 4'b0001, {3'd0,3'd0,3'd0,3'd2}, 4'b0001, 2'b01, 0, 0};
    vecs[12] = '{1'b0, 4'b0001, {3'd0,3'd0,3'd0,3'd3}, 4'b0001, 2'b01, 0, 0};
    vecs[13] = '{1'b0, 4'b0000, {3'd0,3'd0,3'd0,3'd0}, 4'b0000, 2'b00, 0, 0};

    for (int v = 0; v < 14; v++) begin
      @(negedge clk);
      flush     = vecs[v].flush;
      req_valid = vecs[v].valid;
      for (int i = 0; i < 4; i++) begin
        req_rob_id[i] = vecs[v].rob[i];
        req_pd[i]     = pd_of(i, vecs[v].rob[i]);
        req_data[i]   = data_of(i, vecs[v].rob[i]);
      end
      #1 check($sformatf("v%0d_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
      @(posedge clk);
      #1 check($sformatf("v%0d_cdbv", v), 32'(cdb_valid), 32'(vecs[v].exp_cv));
      for (int p = 0; p < 2; p++) begin
        if (vecs[v].exp_cv[p]) begin
          int s;
          s = (p == 0) ? vecs[v].src0 : vecs[v].src1;
          check($sformatf("v%0d_s%0d_rob", v, p), 32'(cdb_rob_id[p]), 32'(vecs[v].rob[s]));
          check($sformatf("v%0d_s%0d_pd", v, p), 32'(cdb_pd[p]), 32'(pd_of(s, vecs[v].rob[s])));
          check($sformatf("v%0d_s%0d_data", v, p), cdb_data[p], data_of(s, vecs[v].rob[s]));
        end
      end
    end

    // Flush while the CDB holds a result: visible during flush, gone after.
    @(negedge clk);
    flush = 1'b0;
    req_valid = 4'b0100;
    req_rob_id[2] = 3'd6;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    req_valid = 4'b0000;
    #1 check("flush_cdb_visible", 32'(cdb_valid), 32'h1);
    check("flush_cdb_rob", 32'(cdb_rob_id[0]), 32'd6);
    @(posedge clk);
    #1 check("flush_cdb_cleared", 32'(cdb_valid), 32'h0);
    @(negedge clk);
    idle_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
